// File: rtl/tqvp_spike_odom_encoder_if.sv
// tqvp_spike_odom_encoder_if: register bus, pause input and spike outputs of the odometry spike encoder
interface tqvp_spike_odom_encoder_if;
    logic [7:0]  ui_in;
    logic [7:0]  uo_out;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;
    logic        user_interrupt;
    modport master (
        output ui_in, address, data_in, data_write_n, data_read_n,
        input  uo_out, data_out, data_ready, user_interrupt
    );
    modport slave (
        input  ui_in, address, data_in, data_write_n, data_read_n,
        output uo_out, data_out, data_ready, user_interrupt
    );
endinterface

// File: rtl/tqvp_spike_odom_encoder.sv
// tqvp_spike_odom_encoder: queued direction/count commands played out as timed spikes on four odometry lines
module tqvp_spike_odom_encoder #(
    parameter int FIFO_DEPTH = 4
) (
    input logic clk,
    input logic rst,
    tqvp_spike_odom_encoder_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;
    state_t      r_state, w_nxt_state;
    logic [7:0]  r_phase, w_nxt_phase;
    logic [15:0] r_rem, w_nxt_rem;
    logic [1:0]  r_dir, w_nxt_dir;
    logic        r_en, r_irq_en, r_ovf, r_irq;
    logic [7:0]  r_hl, r_ll;
    logic [31:0] r_total;
    logic [3:0]  r_spike;
    logic [AW-1:0] r_wptr, r_rptr;
    logic [LW-1:0] r_level;
    logic [17:0] r_fifo [FIFO_DEPTH];
    logic        w_wr, w_wr_cmd, w_wr_ctrl, w_wr_total, w_wr_clr;
    logic        w_pause, w_empty, w_full, w_busy;
    logic        w_pop, w_push, w_inc, w_done, w_ovf_evt, w_irq_set;
    logic [17:0] w_head;
    logic [7:0]  w_hl_m1, w_ll_m1;
    logic        w_unused;
    assign w_wr       = bus.data_write_n != 2'b11;
    assign w_wr_cmd   = w_wr && bus.address == 6'h00;
    assign w_wr_ctrl  = w_wr && bus.address == 6'h04;
    assign w_wr_total = w_wr && bus.address == 6'h0C;
    assign w_wr_clr   = w_wr && bus.address == 6'h10;
    assign w_pause    = bus.ui_in[0];
    assign w_empty    = r_level == '0;
    assign w_full     = r_level == LW'(FIFO_DEPTH);
    assign w_busy     = r_state != S_IDLE;
    assign w_head     = r_fifo[r_rptr];
    // Phase counters count down to 0, so a programmed length of 0 acts as 1
    assign w_hl_m1    = (r_hl == 8'd0) ? 8'd0 : r_hl - 8'd1;
    assign w_ll_m1    = (r_ll == 8'd0) ? 8'd0 : r_ll - 8'd1;
    assign w_push     = w_wr_cmd && (!w_full || w_pop);
    assign w_ovf_evt  = w_wr_cmd && w_full && !w_pop;
    assign w_irq_set  = r_irq_en && (w_ovf_evt || (w_done && w_empty));
    assign w_unused   = &{1'b0, bus.ui_in[7:1], bus.data_read_n, bus.data_in[31:24], bus.data_in[7:2]};
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_phase = r_phase;
        w_nxt_rem   = r_rem;
        w_nxt_dir   = r_dir;
        w_pop       = 1'b0;
        w_inc       = 1'b0;
        w_done      = 1'b0;
        if (!w_pause) begin
            case (r_state)
                S_IDLE: if (r_en && !w_empty) begin
                    w_pop = 1'b1;
                    if (w_head[15:0] != 16'd0) begin
                        w_nxt_state = S_HIGH;
                        w_nxt_dir   = w_head[17:16];
                        w_nxt_rem   = w_head[15:0];
                        w_nxt_phase = w_hl_m1;
                        w_inc       = 1'b1;
                    end
                end
                S_HIGH: begin
                    w_nxt_phase = (r_phase == 8'd0) ? w_ll_m1 : r_phase - 8'd1;
                    w_nxt_state = (r_phase == 8'd0) ? S_LOW : S_HIGH;
                    w_nxt_rem   = (r_phase == 8'd0) ? r_rem - 16'd1 : r_rem;
                end
                S_LOW: if (r_phase != 8'd0) w_nxt_phase = r_phase - 8'd1;
                else if (r_rem != 16'd0 && r_en) begin
                    w_nxt_state = S_HIGH;
                    w_nxt_phase = w_hl_m1;
                    w_inc       = 1'b1;
                end else begin
                    w_nxt_state = S_IDLE;
                    w_nxt_rem   = 16'd0;
                    w_done      = 1'b1;
                end
                default: w_nxt_state = S_IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_phase  <= 8'd0;
            r_rem    <= 16'd0;
            r_dir    <= 2'd0;
            r_en     <= 1'b0;
            r_irq_en <= 1'b0;
            r_hl     <= 8'd0;
            r_ll     <= 8'd0;
            r_ovf    <= 1'b0;
            r_irq    <= 1'b0;
            r_total  <= 32'd0;
            r_spike  <= 4'd0;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_level  <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_phase <= w_nxt_phase;
            r_rem   <= w_nxt_rem;
            r_dir   <= w_nxt_dir;
            r_spike <= (w_nxt_state == S_HIGH) ? 4'b0001 << w_nxt_dir : 4'd0;
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop) r_rptr <= r_rptr + AW'(1);
            r_level <= r_level + LW'(w_push) - LW'(w_pop);
            if (w_wr_ctrl) begin
                r_en     <= bus.data_in[0];
                r_irq_en <= bus.data_in[1];
                r_hl     <= bus.data_in[15:8];
                r_ll     <= bus.data_in[23:16];
            end
            r_ovf   <= w_ovf_evt | (r_ovf & ~(w_wr_clr & bus.data_in[1]));
            r_irq   <= w_irq_set | (r_irq & ~(w_wr_clr & bus.data_in[0]));
            r_total <= w_wr_total ? 32'(w_inc) : r_total + 32'(w_inc);
        end
    end
    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wptr] <= bus.data_in[17:0];
    end
    assign bus.data_out = (bus.address == 6'h04) ? {8'd0, r_ll, r_hl, 6'd0, r_irq_en, r_en} :
                          (bus.address == 6'h08) ? {r_rem, 8'd0, 4'(r_level), r_ovf, w_empty, w_full, w_busy} :
                          (bus.address == 6'h0C) ? r_total : 32'd0;
    // Gated by rst so every line, including fifo_empty, reads 0 while reset is held
    assign bus.uo_out         = rst ? 8'd0 : {r_irq, r_ovf, w_empty, w_busy, r_spike};
    assign bus.data_ready     = 1'b1;
    assign bus.user_interrupt = r_irq;
endmodule

// File: tb/tb_tqvp_spike_odom_encoder.sv
// tb_tqvp_spike_odom_encoder: directed scenarios plus randomized command streams against a spike-trace model
module tb_tqvp_spike_odom_encoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    logic [7:0] cap[$];
    always #5 clk = ~clk;
    tqvp_spike_odom_encoder_if bus();
    tqvp_spike_odom_encoder #(.FIFO_DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        bus.address = a;
        bus.data_in = d;
        bus.data_write_n = 2'b00;
        @(posedge clk);
        #1;
        bus.data_write_n = 2'b11;
    endtask

    task automatic rd(input logic [5:0] a, output logic [31:0] d);
        bus.address = a;
        #1;
        d = bus.data_out;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        bus.ui_in = 8'd0;
        bus.data_write_n = 2'b11;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic capture(input int n);
        cap.delete();
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            cap.push_back(bus.uo_out);
        end
    endtask

    task automatic test_reset;
        logic [31:0] d;
        rst = 1'b1;
        #1;
        total++;
        if (bus.uo_out !== 8'h00) begin bad++; $display("FAIL rst_uo_out got %h want 00", bus.uo_out); end
        do_reset;
        rd(6'h08, d);
        total++;
        if (d !== 32'h4) begin bad++; $display("FAIL reset_status got %h want 00000004", d); end
        rd(6'h04, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL reset_ctrl got %h want 0", d); end
        rd(6'h0C, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL reset_total got %h want 0", d); end
        rd(6'h14, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL unmapped_read got %h want 0", d); end
        total++;
        if (bus.uo_out !== 8'h20 || bus.user_interrupt !== 1'b0 || bus.data_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_outputs got uo=%h irq=%b rdy=%b want 20 0 1", bus.uo_out, bus.user_interrupt, bus.data_ready);
        end
    endtask

    task automatic test_basic;
        logic [3:0] exp[$] = '{0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0};
        logic [31:0] d;
        int e = -1;
        do_reset;
        wr(6'h04, 32'h00020101);
        wr(6'h00, 32'h00000003);
        capture(exp.size());
        foreach (exp[i]) if (e < 0 && cap[i][3:0] !== exp[i]) e = i;
        total++;
        if (e >= 0) begin bad++; $display("FAIL basic_trace cycle %0d got %h want %h", e, cap[e][3:0], exp[e]); end
        rd(6'h0C, d);
        total++;
        if (d !== 32'd3) begin bad++; $display("FAIL basic_total got %0d want 3", d); end
        rd(6'h08, d);
        total++;
        if (d !== 32'h4) begin bad++; $display("FAIL basic_status got %h want 00000004", d); end
        wr(6'h0C, 32'h0);
        rd(6'h0C, d);
        total++;
        if (d !== 32'd0) begin bad++; $display("FAIL total_clear got %0d want 0", d); end
    endtask

    task automatic test_irq;
        logic [7:0] exp[$] = '{8'h00, 8'h08, 8'h00, 8'h08, 8'h00, 8'h80};
        int e = -1;
        do_reset;
        wr(6'h04, 32'h00000103);
        wr(6'h00, 32'h00030002);
        capture(exp.size());
        foreach (exp[i]) if (e < 0 && (cap[i] & 8'h8F) !== exp[i]) e = i;
        total++;
        if (e >= 0) begin bad++; $display("FAIL irq_trace cycle %0d got %h want %h", e, cap[e] & 8'h8F, exp[e]); end
        total++;
        if (bus.user_interrupt !== 1'b1) begin bad++; $display("FAIL irq_set got %b want 1", bus.user_interrupt); end
        wr(6'h10, 32'h1);
        total++;
        if (bus.user_interrupt !== 1'b0) begin bad++; $display("FAIL irq_clear got %b want 0", bus.user_interrupt); end
    endtask

    task automatic test_overflow;
        logic [31:0] d;
        do_reset;
        wr(6'h04, 32'h0);
        for (int i = 0; i < 5; i++) wr(6'h00, {14'd0, 2'($urandom), 16'($urandom)});
        rd(6'h08, d);
        total++;
        if (d !== 32'h4A) begin bad++; $display("FAIL ovf_status got %h want 0000004a", d); end
        total++;
        if (bus.uo_out !== 8'h40) begin bad++; $display("FAIL ovf_uo_out got %h want 40", bus.uo_out); end
        wr(6'h10, 32'h2);
        rd(6'h08, d);
        total++;
        if (d !== 32'h42) begin bad++; $display("FAIL ovf_clear got %h want 00000042", d); end
        wr(6'h04, 32'h2);
        wr(6'h00, 32'h1);
        total++;
        if (bus.user_interrupt !== 1'b1 || bus.uo_out[6] !== 1'b1) begin
            bad++;
            $display("FAIL ovf_irq got irq=%b ovf=%b want 1 1", bus.user_interrupt, bus.uo_out[6]);
        end
    endtask

    task automatic test_pause;
        logic [31:0] d;
        int cnt = 0;
        logic seen_low = 1'b0;
        logic held = 1'b1;
        do_reset;
        wr(6'h04, 32'h00012801);
        wr(6'h00, 32'h00000064);
        for (int k = 0; k < 80; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (bus.uo_out[0] && !seen_low) cnt++;
            if (cnt > 0 && !bus.uo_out[0]) seen_low = 1'b1;
            if (k >= 6 && k <= 25 && bus.uo_out[0] !== 1'b1) held = 1'b0;
            if (k == 5) bus.ui_in = 8'h01;
            if (k == 15) begin
                rd(6'h08, d);
                total++;
                if (d[31:16] !== 16'd100) begin bad++; $display("FAIL pause_remaining got %0d want 100", d[31:16]); end
            end
            if (k == 25) bus.ui_in = 8'h00;
        end
        total++;
        if (!held) begin bad++; $display("FAIL pause_hold got line low want high"); end
        total++;
        if (cnt !== 60) begin bad++; $display("FAIL pause_high_len got %0d want 60", cnt); end
        rd(6'h08, d);
        total++;
        if (d[31:16] !== 16'd99) begin bad++; $display("FAIL pause_after got %0d want 99", d[31:16]); end
    endtask

    task automatic test_zero;
        logic [3:0] exp[$] = '{0, 2, 0, 0, 0, 0};
        logic [31:0] d;
        int e = -1;
        do_reset;
        wr(6'h04, 32'h00000101);
        wr(6'h00, 32'h00000000);
        wr(6'h00, 32'h00010001);
        capture(exp.size());
        foreach (exp[i]) if (e < 0 && cap[i][3:0] !== exp[i]) e = i;
        total++;
        if (e >= 0) begin bad++; $display("FAIL zero_trace cycle %0d got %h want %h", e, cap[e][3:0], exp[e]); end
        rd(6'h0C, d);
        total++;
        if (d !== 32'd1) begin bad++; $display("FAIL zero_total got %0d want 1", d); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        do_reset;
        wr(6'h04, 32'h00000A01);
        wr(6'h00, 32'h00000005);
        @(posedge clk);
        #3;
        total++;
        if (bus.uo_out[0] !== 1'b1) begin bad++; $display("FAIL mid_pre got %b want 1", bus.uo_out[0]); end
        rst = 1'b1;
        #1;
        total++;
        if (bus.uo_out !== 8'h00) begin bad++; $display("FAIL mid_async got %h want 00", bus.uo_out); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        rd(6'h04, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL mid_ctrl got %h want 0", d); end
        rd(6'h08, d);
        total++;
        if (d !== 32'h4) begin bad++; $display("FAIL mid_status got %h want 00000004", d); end
        rd(6'h0C, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL mid_total got %h want 0", d); end
        wr(6'h04, 32'h00000101);
        wr(6'h00, 32'h00000001);
        capture(2);
        total++;
        if (cap[0][3:0] !== 4'h0 || cap[1][3:0] !== 4'h1) begin
            bad++;
            $display("FAIL mid_latency got %h %h want 0 1", cap[0][3:0], cap[1][3:0]);
        end
    endtask

    task automatic test_random;
        for (int it = 0; it < 10; it++) begin
            int n;
            int hl;
            int ll;
            int ie;
            int sum;
            int e;
            logic [1:0] dirs[4];
            int cnts[4];
            logic [3:0] exp[$];
            logic [31:0] d;
            logic ei;
            n = $urandom_range(1, 4);
            hl = $urandom_range(0, 3);
            ll = $urandom_range(0, 3);
            ie = $urandom_range(0, 1);
            sum = 0;
            e = -1;
            do_reset;
            wr(6'h04, {8'd0, 8'(ll), 8'(hl), 6'd0, 1'(ie), 1'b0});
            for (int i = 0; i < n; i++) begin
                dirs[i] = 2'($urandom);
                cnts[i] = $urandom_range(0, 4);
                sum += cnts[i];
                wr(6'h00, {14'd0, dirs[i], 16'(cnts[i])});
            end
            exp.push_back(4'd0);
            for (int i = 0; i < n; i++) begin
                for (int r = 0; r < cnts[i]; r++) begin
                    for (int h = 0; h < (hl == 0 ? 1 : hl); h++) exp.push_back(4'b0001 << dirs[i]);
                    for (int l = 0; l < (ll == 0 ? 1 : ll); l++) exp.push_back(4'd0);
                end
                exp.push_back(4'd0);
            end
            wr(6'h04, {8'd0, 8'(ll), 8'(hl), 6'd0, 1'(ie), 1'b1});
            capture(exp.size());
            foreach (exp[i]) if (e < 0 && cap[i][3:0] !== exp[i]) e = i;
            total++;
            if (e >= 0) begin bad++; $display("FAIL rand_trace iter %0d cycle %0d got %h want %h", it, e, cap[e][3:0], exp[e]); end
            rd(6'h0C, d);
            total++;
            if (d !== 32'(sum)) begin bad++; $display("FAIL rand_total iter %0d got %0d want %0d", it, d, sum); end
            ei = (ie != 0) && (cnts[n-1] != 0);
            total++;
            if (bus.user_interrupt !== ei) begin bad++; $display("FAIL rand_irq iter %0d got %b want %b", it, bus.user_interrupt, ei); end
            @(posedge clk);
            #1;
            rd(6'h08, d);
            total++;
            if (d !== 32'h4) begin bad++; $display("FAIL rand_status iter %0d got %h want 00000004", it, d); end
        end
    endtask

    initial begin
        bus.ui_in = 8'd0;
        bus.address = 6'd0;
        bus.data_in = 32'd0;
        bus.data_write_n = 2'b11;
        bus.data_read_n = 2'b11;
        test_reset;
        test_basic;
        test_irq;
        test_overflow;
        test_pause;
        test_zero;
        test_reset_mid;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
